// File: rtl/approx_mac_accum.sv
// Accumulates a programmed number of 16-bit unsigned products into one ACC_W-bit
// result, presented with valid/ready and a sticky overflow flag.
module approx_mac_accum #(
    parameter int ACC_W    = 24,
    parameter int LEN_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    input  logic             prod_valid_i,
    output logic             prod_ready_o,
    input  logic [15:0]      prod_in_i,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic [ACC_W-1:0] acc_out_o,
    output logic             acc_ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               beat;
    logic [ACC_W:0]     sum;

    // One extra bit on the adder exposes the carry that marks overflow.
    assign beat = (state_q == S_ACCUM) && prod_valid_i;
    assign sum  = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod_in_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = len_i;
                    state_d = (len_i == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    count_d = count_q - 1'b1;
                    if (sum[ACC_W]) begin
                        ovf_d = 1'b1;
                        acc_d = SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    if (count_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (acc_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs come straight from the state register.
    assign busy_o       = (state_q != S_IDLE);
    assign prod_ready_o = (state_q == S_ACCUM);
    assign acc_valid_o  = (state_q == S_DONE);
    assign acc_out_o    = acc_q;
    assign acc_ovf_o    = ovf_q;

endmodule

// File: tb/tb_approx_mac_accum.sv
// Drives three accumulator configurations (24-bit saturating, 17-bit saturating,
// 17-bit wrapping) with shared stimulus and checks them against a run-total model.
module tb_approx_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        prod_valid = 1'b0;
    logic [15:0] prod_in = 16'd0;
    logic        acc_ready = 1'b0;

    logic        b0, pr0, av0, ov0;
    logic [23:0] ao0;
    logic        b1, pr1, av1, ov1;
    logic [16:0] ao1;
    logic        b2, pr2, av2, ov2;
    logic [16:0] ao2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    approx_mac_accum #(.ACC_W(24), .LEN_W(8), .SATURATE(1'b1)) u_d24 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .len_i(len), .busy_o(b0),
        .prod_valid_i(prod_valid), .prod_ready_o(pr0), .prod_in_i(prod_in),
        .acc_valid_o(av0), .acc_ready_i(acc_ready), .acc_out_o(ao0), .acc_ovf_o(ov0));

    approx_mac_accum #(.ACC_W(17), .LEN_W(8), .SATURATE(1'b1)) u_d17s (
        .clk(clk), .rst_n(rst_n), .start_i(start), .len_i(len), .busy_o(b1),
        .prod_valid_i(prod_valid), .prod_ready_o(pr1), .prod_in_i(prod_in),
        .acc_valid_o(av1), .acc_ready_i(acc_ready), .acc_out_o(ao1), .acc_ovf_o(ov1));

    approx_mac_accum #(.ACC_W(17), .LEN_W(8), .SATURATE(1'b0)) u_d17w (
        .clk(clk), .rst_n(rst_n), .start_i(start), .len_i(len), .busy_o(b2),
        .prod_valid_i(prod_valid), .prod_ready_o(pr2), .prod_in_i(prod_in),
        .acc_valid_o(av2), .acc_ready_i(acc_ready), .acc_out_o(ao2), .acc_ovf_o(ov2));

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the exact unbounded sum of the run's products; each width then
    // clamps or wraps it, and overflow is simply "the true sum did not fit".
    localparam int P_IDLE = 0, P_RUN = 1, P_RESULT = 2;
    int     m_phase = P_IDLE;
    int     m_left = 0;
    longint m_total = 0;

    function automatic longint exp_out(input longint tot, input int w, input bit sat);
        longint mx;
        mx = (64'd1 << w) - 1;
        if (tot > mx) return sat ? mx : (tot & mx);
        return tot;
    endfunction

    function automatic longint exp_ovf(input longint tot, input int w);
        return (tot > ((64'd1 << w) - 1)) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE;
            m_left  <= 0;
            m_total <= 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    m_total <= 0;
                    if (len == 8'd0) m_phase <= P_RESULT;
                    else begin
                        m_phase <= P_RUN;
                        m_left  <= int'(len);
                    end
                end
                P_RUN: if (prod_valid) begin
                    m_total <= m_total + longint'(prod_in);
                    m_left  <= m_left - 1;
                    if (m_left == 1) m_phase <= P_RESULT;
                end
                default: if (acc_ready) m_phase <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy24",  64'(b0),  (m_phase != P_IDLE) ? 1 : 0);
            chk("prdy24",  64'(pr0), (m_phase == P_RUN) ? 1 : 0);
            chk("avld24",  64'(av0), (m_phase == P_RESULT) ? 1 : 0);
            chk("out24",   64'(ao0), exp_out(m_total, 24, 1'b1));
            chk("ovf24",   64'(ov0), exp_ovf(m_total, 24));
            chk("busy17s", 64'(b1),  (m_phase != P_IDLE) ? 1 : 0);
            chk("avld17s", 64'(av1), (m_phase == P_RESULT) ? 1 : 0);
            chk("out17s",  64'(ao1), exp_out(m_total, 17, 1'b1));
            chk("ovf17s",  64'(ov1), exp_ovf(m_total, 17));
            chk("prdy17w", 64'(pr2), (m_phase == P_RUN) ? 1 : 0);
            chk("out17w",  64'(ao2), exp_out(m_total, 17, 1'b0));
            chk("ovf17w",  64'(ov2), exp_ovf(m_total, 17));
        end
    end

    logic [15:0] prod_q [$];
    logic [23:0] res0;
    logic [16:0] res1, res2;
    logic        rov0, rov1, rov2;
    int          wait_cycles;

    // One complete run: start, feed prod_q with fixed gaps, stall the result
    // for rdy_wait cycles, then handshake. Optional start pokes while busy.
    task automatic do_run(input int n, input int gap, input int rdy_wait, input bit poke);
        int t;
        start = 1'b1;
        len   = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                prod_valid = 1'b0;
                prod_in    = 16'($urandom);
                start      = poke;
                @(posedge clk); #1;
                start = 1'b0;
            end
            prod_valid = 1'b1;
            prod_in    = prod_q[i];
            t = 0;
            while (!pr0 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 20) chk("prod_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        prod_valid = 1'b0;
        t = 0;
        while (!av0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        wait_cycles = t;
        if (t >= 20) chk("acc_valid_timeout", 0, 1);
        res0 = ao0; res1 = ao1; res2 = ao2;
        rov0 = ov0; rov1 = ov1; rov2 = ov2;
        for (int k = 0; k < rdy_wait; k++) begin
            acc_ready = 1'b0;
            start     = poke && (k == 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("stall_hold24", 64'(ao0), 64'(res0));
        acc_ready = 1'b1;
        start     = poke;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        start     = 1'b0;
        chk("busy_after_hs", 64'(b0), 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", 64'(b0), 0);
        chk("rst_out",  64'(ao0), 0);
        chk("rst_avld", 64'(av0), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset two beats into a four-beat run.
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0; prod_valid = 1'b1; prod_in = 16'h0007;
        @(posedge clk); #1;
        prod_in = 16'h0009;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(b0), 0);
        chk("arst_out",  64'(ao0), 0);
        chk("arst_ovf",  64'(ov0), 0);
        chk("arst_avld", 64'(av0), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        prod_q = '{16'h0005};
        do_run(1, 0, 0, 1'b0);
        chk("after_rst_out", 64'(res0), 64'h5);

        // Back-to-back four-beat run.
        prod_q = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        do_run(4, 0, 0, 1'b0);
        chk("b2b_out", 64'(res0), 64'hA0);
        chk("b2b_ovf", 64'(rov0), 0);
        chk("b2b_latency", 64'(wait_cycles), 0);

        // Gapped beats, stalled result, starts poked while busy.
        prod_q = '{16'h1234, 16'h0101, 16'h00FF};
        do_run(3, 2, 5, 1'b1);
        chk("gap_out", 64'(res0), 64'h1434);

        // Empty run.
        prod_valid = 1'b1; prod_in = 16'h7777;
        prod_q = {};
        do_run(0, 0, 1, 1'b0);
        chk("empty_out", 64'(res0), 0);
        chk("empty_latency", 64'(wait_cycles), 0);

        // Narrow accumulators overflowing.
        prod_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        do_run(3, 0, 0, 1'b0);
        chk("sat17_out",  64'(res1), 64'h1FFFF);
        chk("sat17_ovf",  64'(rov1), 1);
        chk("wrap17_out", 64'(res2), 64'h0FFFD);
        chk("wrap17_ovf", 64'(rov2), 1);

        // Longest run, then flags cleared on the next start.
        prod_q = {};
        for (int i = 0; i < 255; i++) prod_q.push_back(16'hFFFF);
        do_run(255, 0, 0, 1'b0);
        chk("max_out", 64'(res0), 64'hFEFF01);
        chk("max_ovf", 64'(rov0), 0);
        chk("sat17_max_out", 64'(res1), 64'h1FFFF);
        prod_q = '{16'h0001};
        do_run(1, 0, 0, 1'b0);
        chk("next_out", 64'(res0), 64'h1);
        chk("next_ovf17", 64'(rov1), 0);

        // Randomized runs with idle noise between them.
        for (int r = 0; r < 40; r++) begin
            int n;
            int gap;
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
            gap = (n > 16) ? 0 : int'($urandom_range(0, 2));
            prod_q = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: prod_q.push_back(16'hFFFF);
                    1: prod_q.push_back(16'h0000);
                    default: prod_q.push_back(16'($urandom));
                endcase
            end
            do_run(n, gap, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                prod_valid = 1'($urandom);
                prod_in    = 16'($urandom);
                acc_ready  = 1'($urandom);
                len        = 8'($urandom);
                @(posedge clk); #1;
            end
            prod_valid = 1'b0;
            acc_ready  = 1'b0;
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
